mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Arbitrates the single physical memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Sits between the NPC core and the memory model/bus, replacing the direct memory reads in the core.
- Registers one request at a time and issues it downstream over a valid/ready request channel.
- Waits for the downstream response, with a timeout, then returns the response to the originating requester.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (wmask width = DATA_W/8)
- TIMEOUT_CYC, 255, max cycles in WAIT before error response (≥1, counter width = clog2(TIMEOUT_CYC+1))

Ports:
- Clock and reset:
  - clk  in  1  single clock, rising edge.
  - reset  in  1  asynchronous, active-low reset: all state clears while reset=0.
- IFU channel:
  - ifu_req_valid  in  1  IFU request.
  - ifu_req_ready  out  1  IFU request accepted.
  - ifu_addr  in  ADDR_W  fetch address.
  - ifu_rsp_valid  out  1  IFU response valid.
  - ifu_rsp_ready  in  1  IFU takes response.
  - ifu_rdata  out  DATA_W  fetched word.
  - ifu_rsp_err  out  1  timeout error.
- LSU channel:
  - lsu_req_valid / lsu_req_ready  in/out  1  LSU request handshake.
  - lsu_addr  in  ADDR_W  access address.
  - lsu_wen  in  1  1=store, 0=load.
  - lsu_wdata  in  DATA_W  store data.
  - lsu_wmask  in  DATA_W/8  byte enables.
  - lsu_rsp_valid / lsu_rsp_ready  out/in  1  LSU response handshake.
  - lsu_rdata  out  DATA_W  load data (undefined for stores).
  - lsu_rsp_err  out  1  timeout error.
- Memory channel:
  - mem_req_valid / mem_req_ready  out/in  1  downstream request handshake.
  - mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  registered request fields.
  - mem_rsp_valid / mem_rsp_ready  in/out  1  downstream response handshake.
  - mem_rdata  in  DATA_W  response data.
- Status:
  - busy  out  1  state ≠ IDLE.
  - owner  out  1  0=IFU, 1=LSU; owner of current/last transaction.

## Operation
States:
- IDLE:
  - Grant is combinational from the valid inputs. ready is asserted only to the granted requester.
  - On valid&ready, latch addr/wen/wdata/wmask and owner, then go to ISSUE.
  - IFU requests are latched with wen=0 and wmask=0.
- ISSUE: mem_req_valid=1 with latched fields. On mem_req_ready, go to WAIT and clear the timeout counter.
- WAIT:
  - mem_rsp_ready=1 and the counter increments.
  - On mem_rsp_valid, latch mem_rdata, set err=0, go to RESP.
  - Otherwise, when counter==TIMEOUT_CYC, set rdata=0 and err=1, go to RESP.
- RESP:
  - Owner's rsp_valid=1, driving rdata and err from registers.
  - On rsp_ready, go to IDLE.
- Non-owner rsp_valid is always 0.

Handshake rules:
- mem_req fields are stable while mem_req_valid=1 and not accepted.
- mem_rsp_ready=0 outside WAIT. A response arriving in the same cycle as the timeout wins: err=0.
- Stores also complete through RESP, so the LSU always waits for its response.
- Requesters may drop valid without a handshake; nothing is latched in that case.

## Timing
- Reset values: all ready/valid outputs 0, rdata 0, err 0, busy 0, owner 0. mem_* fields 0. State IDLE, last_grant=1 (LSU).
- A reset assertion mid-transaction aborts the transaction immediately. The downstream transaction is abandoned and no response is delivered.
- Request ready is combinational from valid in IDLE. All other outputs are registered state.
- Minimum latency, with zero-wait memory and a requester ready for the response:
  - accept at edge N;
  - mem_req_valid during cycle N+1, accepted at edge N+1;
  - mem_rsp_valid during N+2;
  - rsp_valid during N+3, handshake at edge N+3.
  - Next accept is possible at edge N+4.
- Throughput: one transaction per ≥4 cycles; no overlap.
- Timeout: err response appears TIMEOUT_CYC+1 cycles after entering WAIT.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - When both requesters are valid in IDLE, grant the one ≠ last_grant.
  - last_grant updates on each accept.
  - After reset, the IFU wins the first contention.
- MEM_ARB_RR_EN undefined: fixed priority, LSU over IFU. last_grant is not implemented.

## Test plan
- Single IFU read, addr=0x80000000, memory returns 0x00100073 with zero wait:
  - ifu_rsp_valid on cycle 4 with rdata=0x00100073, err=0, owner=0.
- LSU store, addr=0x80001000, wdata=0x12345678, wmask=4'b0001:
  - mem_wen=1, mem_wmask=4'b0001, mem_wdata=0x12345678 held while mem_req_ready=0 for 3 cycles;
  - then lsu_rsp_valid with err=0.
- Both requesters valid continuously for 4 transactions:
  - fixed priority: LSU,LSU,LSU,LSU;
  - MEM_ARB_RR_EN: IFU,LSU,IFU,LSU.
- Memory never asserts mem_rsp_valid, TIMEOUT_CYC=8:
  - lsu_rsp_valid 9 cycles after WAIT entry, err=1, rdata=0;
  - mem_rsp_ready=0 afterwards.
- mem_rsp_valid exactly in the timeout cycle: response delivered with err=0 and the memory data.
- reset pulled low during WAIT:
  - all outputs 0 and busy=0 immediately, no ifu/lsu_rsp_valid.
  - After release, a new IFU request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between IFU and LSU: one registered request in flight, timeout on response.
// Define MEM_ARB_RR_EN for round-robin grant; otherwise fixed priority with LSU over IFU.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                owner
);
    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int MASK_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ifu_gnt, lsu_gnt;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        lsu_gnt      = lsu_req_valid && (!ifu_req_valid || !last_grant_q);
        ifu_gnt      = ifu_req_valid && !lsu_gnt;
        last_grant_d = last_grant_q;
        if (state_q == S_IDLE && (ifu_gnt || lsu_gnt)) begin
            last_grant_d = lsu_gnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign lsu_gnt = lsu_req_valid;
    assign ifu_gnt = ifu_req_valid && !lsu_req_valid;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_gnt) begin
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                    owner_d = 1'b1;
                    state_d = S_ISSUE;
                end else if (ifu_gnt) begin
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    owner_d = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response landing in the timeout cycle still counts as success.
                if (mem_rsp_valid) begin
                    rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == TMO) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (owner_q ? lsu_rsp_ready : ifu_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ifu_req_ready = (state_q == S_IDLE) && ifu_gnt;
    assign lsu_req_ready = (state_q == S_IDLE) && lsu_gnt;
    assign mem_req_valid = (state_q == S_ISSUE);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign mem_rsp_ready = (state_q == S_WAIT);
    assign ifu_rsp_valid = (state_q == S_RESP) && !owner_q;
    assign lsu_rsp_valid = (state_q == S_RESP) && owner_q;
    assign ifu_rdata     = rdata_q;
    assign lsu_rdata     = rdata_q;
    assign ifu_rsp_err   = err_q;
    assign lsu_rsp_err   = err_q;
    assign busy          = (state_q != S_IDLE);
    assign owner         = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, a configurable memory responder and a response monitor.
module tb_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [3:0]    lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_wmask;
    logic          busy, owner;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
        .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
        .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   mem_stall = 0;
    int   rsp_lat   = 0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0010_0073 : (a ^ 32'h5A5A_1234);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic score(input logic src, input logic [31:0] rd, input logic er);
        exp_t e;
        if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: response on %s with empty scoreboard", src ? "LSU" : "IFU");
        end else begin
            e = sbq.pop_front();
            chk("rsp_channel", 64'(src), 64'(e.owner));
            chk("rsp_owner", 64'(owner), 64'(e.owner));
            chk("rsp_err", 64'(er), 64'(e.err));
            if (e.chk_data) chk("rsp_rdata", 64'(rd), 64'(e.rdata));
        end
    endtask

    // Memory responder: stalls the request mem_stall cycles, answers rsp_lat cycles into WAIT (never if <0).
    initial begin
        int stall_cnt;
        int wait_cnt;
        logic [31:0] lat_addr;
        stall_cnt = 0;
        wait_cnt  = 0;
        lat_addr  = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (mem_req_valid) begin
                if (stall_cnt < mem_stall) begin
                    stall_cnt++;
                end else begin
                    mem_req_ready = 1'b1;
                    stall_cnt = 0;
                    wait_cnt  = 0;
                    lat_addr  = mem_addr;
                end
            end else if (mem_rsp_ready) begin
                if (rsp_lat >= 0 && wait_cnt == rsp_lat) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = mem_val(lat_addr);
                end
                wait_cnt++;
            end
        end
    end

    // Response monitor
    initial begin
        forever begin
            @(negedge clk);
            if (ifu_rsp_valid) chk("rsp_exclusive", 64'(lsu_rsp_valid), 64'd0);
            if (ifu_rsp_valid && ifu_rsp_ready) score(1'b0, ifu_rdata, ifu_rsp_err);
            if (lsu_rsp_valid && lsu_rsp_ready) score(1'b1, lsu_rdata, lsu_rsp_err);
        end
    end

    task automatic send(input logic is_lsu, input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input logic [3:0] wm, input logic push, input exp_t e);
        logic acc;
        acc = 1'b0;
        @(posedge clk); #1;
        if (is_lsu) begin
            lsu_req_valid = 1'b1; lsu_addr = a; lsu_wen = w; lsu_wdata = wd; lsu_wmask = wm;
        end else begin
            ifu_req_valid = 1'b1; ifu_addr = a;
        end
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (is_lsu ? lsu_req_ready : ifu_req_ready) acc = 1'b1;
        end
        chk("req_accepted", 64'(acc), 64'd1);
        if (acc && push) sbq.push_back(e);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input logic is_lsu, input int exp_lat, input string name);
        int   cnt;
        logic got;
        cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            cnt++;
            if (is_lsu ? lsu_rsp_valid : ifu_rsp_valid) got = 1'b1;
        end
        chk(name, 64'(cnt), 64'(exp_lat));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_acc;
        logic rr_reached;
        exp_t e;
        reset = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = '0; ifu_rsp_ready = 1'b1;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        lsu_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 64'({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid,
                              lsu_rsp_valid, busy, owner, ifu_rsp_err, lsu_rsp_err}), 64'd0);
        chk("reset_mem_fields", {mem_addr, mem_wdata}, 64'd0);
        chk("reset_misc", 64'({mem_wen, mem_wmask, ifu_rdata, lsu_rdata}), 64'd0);
        reset = 1'b1;

        // Zero-wait IFU fetch: response visible three cycles after the accept edge
        mem_stall = 0; rsp_lat = 0;
        e = '{owner: 1'b0, rdata: 32'h0010_0073, err: 1'b0, chk_data: 1'b1};
        send(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b1, e);
        wait_rsp(1'b0, 3, "ifu_latency");

        // Store held on the memory port through three stalled cycles
        mem_stall = 3;
        e = '{owner: 1'b1, rdata: 32'h0, err: 1'b0, chk_data: 1'b0};
        send(1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'b0001, 1'b1, e);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("store_hold_ctl", 64'({mem_req_valid, mem_wen, mem_wmask}), 64'({1'b1, 1'b1, 4'b0001}));
            chk("store_hold_data", {mem_addr, mem_wdata}, {32'h8000_1000, 32'h1234_5678});
        end
        wait_rsp(1'b1, 3, "store_latency");
        mem_stall = 0;

        // Both requesters valid for four transactions
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            rr_reached = (i % 2 == 1);
`else
            rr_reached = 1'b1;
`endif
            e = '{owner: rr_reached, rdata: mem_val(rr_reached ? 32'h8000_0200 : 32'h8000_0100),
                  err: 1'b0, chk_data: 1'b1};
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0; lsu_wmask = 4'hF;
        n_acc = 0;
        for (int i = 0; i < 100 && n_acc < 4; i++) begin
            @(negedge clk);
            if ((ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready)) n_acc++;
        end
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        chk("contention_accepts", 64'(n_acc), 64'd4);
        wait_drain();

        // Memory never answers: error response TMO+1 cycles after WAIT entry
        rsp_lat = -1;
        e = '{owner: 1'b1, rdata: 32'h0, err: 1'b1, chk_data: 1'b1};
        send(1'b1, 32'h8000_2000, 1'b0, 32'h0, 4'hF, 1'b1, e);
        wait_rsp(1'b1, TMO + 3, "timeout_latency");
        chk("timeout_rsp_ready_resp", 64'(mem_rsp_ready), 64'd0);
        @(negedge clk);
        chk("timeout_after", 64'({mem_rsp_ready, busy}), 64'd0);

        // Memory answers exactly in the timeout cycle, and one cycle earlier
        rsp_lat = TMO;
        e = '{owner: 1'b1, rdata: mem_val(32'h8000_3000), err: 1'b0, chk_data: 1'b1};
        send(1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'hF, 1'b1, e);
        wait_rsp(1'b1, TMO + 3, "edge_rsp_latency");
        rsp_lat = TMO - 1;
        e = '{owner: 1'b0, rdata: mem_val(32'h8000_0400), err: 1'b0, chk_data: 1'b1};
        send(1'b0, 32'h8000_0400, 1'b0, 32'h0, 4'h0, 1'b1, e);
        wait_rsp(1'b0, TMO + 2, "early_rsp_latency");
        wait_drain();

        // Reset asserted while waiting on memory aborts the transaction
        rsp_lat = -1;
        e = '{owner: 1'b0, rdata: 32'h0, err: 1'b0, chk_data: 1'b0};
        send(1'b0, 32'h8000_0500, 1'b0, 32'h0, 4'h0, 1'b0, e);
        rr_reached = 1'b0;
        for (int i = 0; i < 20 && !rr_reached; i++) begin
            @(negedge clk);
            if (mem_rsp_ready) rr_reached = 1'b1;
        end
        chk("rst_reached_wait", 64'(rr_reached), 64'd1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_abort_ctl", 64'({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid,
                                  lsu_rsp_valid, busy, owner, ifu_rsp_err}), 64'd0);
        chk("rst_abort_fields", {mem_addr, ifu_rdata}, 64'd0);
        @(negedge clk);
        chk("rst_hold_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid, busy}), 64'd0);
        reset = 1'b1;
        rsp_lat = 0;
        e = '{owner: 1'b0, rdata: 32'h0010_0073, err: 1'b0, chk_data: 1'b1};
        send(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b1, e);
        wait_rsp(1'b0, 3, "post_reset_latency");
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
